// File: rtl/battleship_pkg.sv
// Shared battleship constants: board geometry, cell codes, colours and screen-state codes.
package battleship_pkg;

  localparam int unsigned CELL_SIZE = 14;
  localparam int unsigned GRID_N    = 10;
  localparam int unsigned BOARD0_X  = 10;
  localparam int unsigned BOARD1_X  = 170;
  localparam int unsigned BOARD_Y   = 50;
  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;

  localparam int unsigned X_W     = 9;
  localparam int unsigned Y_W     = 8;
  localparam int unsigned RGB_W   = 3;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned OFS_W   = $clog2(CELL_SIZE);

  typedef enum logic [1:0] {
    CELL_WATER = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_HIT   = 2'd2,
    CELL_MISS  = 2'd3
  } cell_state_t;

  localparam logic [RGB_W-1:0] COL_BLACK  = 3'b000;
  localparam logic [RGB_W-1:0] COL_BLUE   = 3'b001;
  localparam logic [RGB_W-1:0] COL_WHITE  = 3'b111;
  localparam logic [RGB_W-1:0] COL_RED    = 3'b100;
  localparam logic [RGB_W-1:0] COL_YELLOW = 3'b110;

  // Screen-state codes shared with the screen datapath.
  typedef enum logic [1:0] {
    TITLE      = 2'd0,
    GAME_BOARD = 2'd1,
    GAME_OVER  = 2'd2
  } screen_state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] colour;
  } pixel_t;

  function automatic logic [RGB_W-1:0] state_colour(input cell_state_t s);
    case (s)
      CELL_WATER: state_colour = COL_BLUE;
      CELL_SHIP:  state_colour = COL_WHITE;
      CELL_HIT:   state_colour = COL_RED;
      default:    state_colour = COL_YELLOW;
    endcase
  endfunction

endpackage

// File: rtl/cell_pixel_scanner.sv
// Row-major dx/dy offset counter over one cell; exposes next offsets and a last-pixel flag.
module cell_pixel_scanner
  import battleship_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [OFS_W-1:0] dx_c_o,
  output logic [OFS_W-1:0] dy_c_o,
  output logic             last_c_o
);

  localparam logic [OFS_W-1:0] OFS_MAX = OFS_W'(CELL_SIZE - 1);

  logic [OFS_W-1:0] dx_q, dx_d;
  logic [OFS_W-1:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (load_i) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en_i) begin
      if (dx_q == OFS_MAX) begin
        dx_d = '0;
        dy_d = (dy_q == OFS_MAX) ? '0 : dy_q + OFS_W'(1);
      end else begin
        dx_d = dx_q + OFS_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx_c_o   = dx_d;
  assign dy_c_o   = dy_d;
  assign last_c_o = (dx_q == OFS_MAX) && (dy_q == OFS_MAX);

endmodule

// File: rtl/board_cell_renderer.sv
// Paints one battleship grid cell as a CELL_SIZE x CELL_SIZE pixel block, one pixel per clock.
// Define GRID_BORDER_EN to draw the top row and left column of each cell in black.
module board_cell_renderer
  import battleship_pkg::*;
(
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic             board_sel,
  input  logic [IDX_W-1:0] cell_col,
  input  logic [IDX_W-1:0] cell_row,
  input  logic [1:0]       cell_state,
  output logic             busy,
  output logic             done,
  output logic             plot,
  output logic [X_W-1:0]   cell_x_out,
  output logic [Y_W-1:0]   cell_y_out,
  output logic [RGB_W-1:0] cell_colour_out
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

  state_t         state_q, state_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           plot_q, plot_d;
  pixel_t         pix_q, pix_d;
  logic [X_W-1:0] ox_q, ox_d;
  logic [Y_W-1:0] oy_q, oy_d;
  cell_state_t    cst_q, cst_d;

  logic             scan_load_c, scan_en_c, scan_last_c;
  logic [OFS_W-1:0] dx_nxt_c, dy_nxt_c;
  logic             cell_valid_c, border_c;
  logic [X_W-1:0]   start_ox_c;
  logic [Y_W-1:0]   start_oy_c;

  cell_pixel_scanner u_scanner (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .load_i   (scan_load_c),
    .en_i     (scan_en_c),
    .dx_c_o   (dx_nxt_c),
    .dy_c_o   (dy_nxt_c),
    .last_c_o (scan_last_c)
  );

  assign cell_valid_c = (cell_col < IDX_W'(GRID_N)) && (cell_row < IDX_W'(GRID_N));
  assign start_ox_c   = (board_sel ? X_W'(BOARD1_X) : X_W'(BOARD0_X))
                      + X_W'(cell_col) * X_W'(CELL_SIZE);
  assign start_oy_c   = Y_W'(BOARD_Y) + Y_W'(cell_row) * Y_W'(CELL_SIZE);

`ifdef GRID_BORDER_EN
  assign border_c = (dx_nxt_c == '0) || (dy_nxt_c == '0);
`else
  assign border_c = 1'b0;
`endif

  // Next state plus next registered outputs; the pixel is built from the scanner's next offsets.
  always_comb begin
    state_d     = state_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    plot_d      = 1'b0;
    pix_d       = pix_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    cst_d       = cst_q;
    scan_load_c = 1'b0;
    scan_en_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (cell_valid_c) begin
            state_d     = DRAW;
            ox_d        = start_ox_c;
            oy_d        = start_oy_c;
            cst_d       = cell_state_t'(cell_state);
            scan_load_c = 1'b1;
            busy_d      = 1'b1;
            plot_d      = 1'b1;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
          end
        end
      end
      DRAW: begin
        if (scan_last_c) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          scan_en_c = 1'b1;
          busy_d    = 1'b1;
          plot_d    = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (plot_d) begin
      pix_d.x      = ox_d + X_W'(dx_nxt_c);
      pix_d.y      = oy_d + Y_W'(dy_nxt_c);
      pix_d.colour = border_c ? COL_BLACK : state_colour(cst_d);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      plot_q  <= 1'b0;
      pix_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      cst_q   <= CELL_WATER;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      plot_q  <= plot_d;
      pix_q   <= pix_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      cst_q   <= cst_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign plot            = plot_q;
  assign cell_x_out      = pix_q.x;
  assign cell_y_out      = pix_q.y;
  assign cell_colour_out = pix_q.colour;

endmodule
